// File: rtl/pair_serializer.sv
// pair_serializer: shifts one {d1,d2} pair per handshake onto a serial line, MSB-first, with frame marker and idle gap
// Ports: clk/rst (sync, active-high); in_valid/in_ready/d1/d2 upstream handshake;
// ser_out/ser_valid/frame_start serial link; busy high during SHIFT and GAP.
// Define PAIR_SERIALIZER_PARITY_EN to append an even-parity bit after each byte.
module pair_serializer #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);
`ifdef PAIR_SERIALIZER_PARITY_EN
  localparam int FB = 2*WIDTH + 2;
`else
  localparam int FB = 2*WIDTH;
`endif
  localparam int BW = $clog2(FB + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t r_state, w_state;
  logic [FB-1:0] w_frame, r_shift, w_shift;
  logic [BW-1:0] r_bcnt, w_bcnt;
  logic [GW-1:0] r_gcnt, w_gcnt;
  logic r_ser, r_sv, r_fs, r_busy, r_rdy;
  logic w_ser, w_sv, w_fs, w_busy, w_rdy, w_last_bit, w_last_gap;
`ifdef PAIR_SERIALIZER_PARITY_EN
  assign w_frame = {d1, ^d1, d2, ^d2};
`else
  assign w_frame = {d1, d2};
`endif
  // r_bcnt counts bits already driven onto ser_out, r_gcnt gap cycles already spent
  assign w_last_bit = r_bcnt == BW'(FB);
  assign w_last_gap = r_gcnt == GW'(GAP_CYCLES);
  assign in_ready    = r_rdy;
  assign ser_out     = r_ser;
  assign ser_valid   = r_sv;
  assign frame_start = r_fs;
  assign busy        = r_busy;
  always_comb begin
    w_state = r_state;
    w_shift = r_shift;
    w_bcnt  = r_bcnt;
    w_gcnt  = r_gcnt;
    w_ser   = 1'b0;
    w_sv    = 1'b0;
    w_fs    = 1'b0;
    w_busy  = r_busy;
    w_rdy   = r_rdy;
    case (r_state)
      IDLE: if (in_valid && r_rdy) begin
        // first bit goes straight to the output register; the rest waits in r_shift
        w_state = SHIFT;
        w_shift = w_frame << 1;
        w_ser   = w_frame[FB-1];
        w_sv    = 1'b1;
        w_fs    = 1'b1;
        w_busy  = 1'b1;
        w_rdy   = 1'b0;
        w_bcnt  = BW'(1);
      end
      SHIFT: if (!w_last_bit) begin
        w_shift = r_shift << 1;
        w_ser   = r_shift[FB-1];
        w_sv    = 1'b1;
        w_bcnt  = r_bcnt + 1'b1;
      end else if (GAP_CYCLES == 0) begin
        w_state = IDLE;
        w_busy  = 1'b0;
        w_rdy   = 1'b1;
      end else begin
        w_state = GAP;
        w_gcnt  = GW'(1);
      end
      GAP: if (w_last_gap) begin
        w_state = IDLE;
        w_busy  = 1'b0;
        w_rdy   = 1'b1;
      end else begin
        w_gcnt  = r_gcnt + 1'b1;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bcnt  <= '0;
      r_gcnt  <= '0;
      r_ser   <= 1'b0;
      r_sv    <= 1'b0;
      r_fs    <= 1'b0;
      r_busy  <= 1'b0;
      r_rdy   <= 1'b1;
    end else begin
      r_state <= w_state;
      r_shift <= w_shift;
      r_bcnt  <= w_bcnt;
      r_gcnt  <= w_gcnt;
      r_ser   <= w_ser;
      r_sv    <= w_sv;
      r_fs    <= w_fs;
      r_busy  <= w_busy;
      r_rdy   <= w_rdy;
    end
  end
endmodule
